// File: rtl/alpharetz_spi_pkg.sv
// Shared types and default parameters for the Alpharetz SPI blocks.
package alpharetz_spi_pkg;

  localparam int unsigned SpiDataWidth  = 8;
  localparam int unsigned SpiSyncStages = 2;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } spi_target_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_input_sync.sv
// N-stage flop synchronizer for an asynchronous pin, with a selectable reset value.
module spi_input_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic sync_rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_in) begin
    if (sync_rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI target endpoint: oversamples the SPI pins in the clk_in domain, recovers bits for any
// CPOL/CPHA mode and exchanges words through a receive pulse and a valid/ready transmit port.
module spi_target
  import alpharetz_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SpiDataWidth,
  parameter int unsigned SYNC_STAGES = SpiSyncStages
) (
  input  logic                  clk_in,
  input  logic                  sync_rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int unsigned         CntWidth = $clog2(DATA_WIDTH);
  localparam logic [CntWidth-1:0] LastBit  = CntWidth'(DATA_WIDTH - 1);

  logic cs_sync, sclk_sync, mosi_sync;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_in   (clk_in),
    .sync_rst (sync_rst),
    .d        (cs_n),
    .q        (cs_sync)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_in   (clk_in),
    .sync_rst (sync_rst),
    .d        (sclk),
    .q        (sclk_sync)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_in   (clk_in),
    .sync_rst (sync_rst),
    .d        (mosi),
    .q        (mosi_sync)
  );

  spi_target_state_e     state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [SYNC_STAGES-1:0] flush_q;
  logic sclk_q;
  logic armed_q, armed_d;
  logic pend_q, pend_d;
  logic tx_ready_q, tx_ready_d;
  logic rx_valid_q, rx_valid_d;
  logic underrun_q, underrun_d;
  logic miso_q, miso_d;
  logic oe_q, oe_d;
  logic busy_q, busy_d;

  logic rise, fall, lead, trail, sample_edge, shift_edge, load, hs;

  assign rise        = sclk_sync & ~sclk_q;
  assign fall        = ~sclk_sync & sclk_q;
  assign lead        = mode_q.cpol ? fall : rise;
  assign trail       = mode_q.cpol ? rise : fall;
  assign sample_edge = mode_q.cpha ? trail : lead;
  assign shift_edge  = mode_q.cpha ? lead : trail;
  assign hs          = tx_valid & tx_ready_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    pend_d     = pend_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;
    // Arm only once the synchronizer holds real samples of a deselected cs_n, so a reset
    // taken mid-frame cannot re-enter the frame that is still in progress.
    armed_d    = armed_q | (flush_q[SYNC_STAGES-1] & cs_sync);

    unique case (state_q)
      StIdle: begin
        if (armed_q && !cs_sync) begin
          state_d     = StActive;
          mode_d.cpol = cpol;
          mode_d.cpha = cpha;
          cnt_d       = '0;
          pend_d      = 1'b0;
          tx_shift_d  = '0;
          load        = ~cpha;
        end
      end
      StActive: begin
        if (cs_sync) begin
          state_d = StIdle;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
            if (cnt_q == LastBit) begin
              cnt_d      = '0;
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
              pend_d     = ~mode_q.cpha;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (shift_edge) begin
            if (mode_q.cpha ? (cnt_q == '0) : pend_q) begin
              load   = 1'b1;
              pend_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A load from an empty holding register sends zeros and flags the underrun.
    if (load) begin
      tx_shift_d = tx_ready_q ? '0 : hold_q;
      underrun_d = tx_ready_q;
      tx_ready_d = 1'b1;
    end
    if (hs) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end

    busy_d = (state_d == StActive);
    oe_d   = busy_d;
    miso_d = busy_d ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (sync_rst) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_shift_q <= '0;
      hold_q     <= '0;
      flush_q    <= '0;
      sclk_q     <= 1'b0;
      armed_q    <= 1'b0;
      pend_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      flush_q    <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      sclk_q     <= sclk_sync;
      armed_q    <= armed_d;
      pend_q     <= pend_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// Randomized bench for spi_target: a bit-level SPI controller model drives frames while a
// scoreboard checks received words, transmitted words and underrun pulses.
module tb_spi_target;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          sync_rst = 1'b1;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] rx_data;

  always #5 clk = ~clk;

  spi_target #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk_in      (clk),
    .sync_rst    (sync_rst),
    .cpol        (cpol),
    .cpha        (cpha),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  int            tests = 0;
  int            failures = 0;
  int            underrun_cnt = 0;
  int            half = 4;
  logic          cur_cpol = 1'b0;
  logic          cur_cpha = 1'b0;
  logic [DW-1:0] exp_rx[$];
  logic [DW-1:0] exp_miso[$];
  logic [DW-1:0] feed_q[$];
  logic [DW-1:0] mw[$];
  logic [DW-1:0] tw[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every rx_valid pulse must match the oldest outstanding word.
  always @(negedge clk) begin
    if (tx_underrun) underrun_cnt++;
    if (rx_valid) begin
      check("rx_pending", 32'(exp_rx.size() != 0), 32'd1);
      if (exp_rx.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
  end

  // Transmit feeder: hands queued words over whenever the holding register is empty.
  initial begin
    forever begin
      @(negedge clk);
      if (feed_q.size() != 0 && tx_ready && !sync_rst) begin
        tx_data  = feed_q.pop_front();
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  // One controller bit: drives mosi and returns the miso value seen at the sample edge.
  task automatic xfer_bit(input logic b, output logic m);
    if (!cur_cpha) begin
      mosi = b;
      clk_wait(half);
      m    = miso;
      sclk = ~cur_cpol;
      clk_wait(half);
      sclk = cur_cpol;
    end else begin
      sclk = ~cur_cpol;
      mosi = b;
      clk_wait(half);
      m    = miso;
      sclk = cur_cpol;
      clk_wait(half);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, 32'(miso), 32'd0);
    check({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Runs one frame of nbits with mw as mosi words and the first k entries of tw as tx words.
  // Word loads: CPHA=0 loads at selection and after every completed word; CPHA=1 loads at
  // the start of every word that gets at least one clock.
  task automatic do_frame(input logic pol, input logic pha, input int nbits, input int k);
    int            nfull;
    int            loads;
    int            u0;
    int            waited;
    logic          m;
    logic [DW-1:0] cap;
    logic [DW-1:0] w;
    nfull = nbits / DW;
    loads = pha ? nfull + (((nbits % DW) != 0) ? 1 : 0) : nfull + 1;
    for (int i = 0; i < nfull; i++) begin
      exp_rx.push_back(mw[i]);
      exp_miso.push_back((i < k) ? tw[i] : '0);
    end
    for (int i = 0; i < k; i++) feed_q.push_back(tw[i]);
    cur_cpol = pol;
    cur_cpha = pha;
    cpol     = pol;
    cpha     = pha;
    sclk     = pol;
    mosi     = 1'b0;
    waited   = 0;
    while (k > 0 && tx_ready && waited < 20) begin
      clk_wait(1);
      waited++;
    end
    if (k > 0) check("tx_preload_ready", 32'(tx_ready), 32'd0);
    clk_wait(6);
    u0   = underrun_cnt;
    cs_n = 1'b0;
    clk_wait(3);
    check("busy_active", 32'(busy), 32'd1);
    check("miso_oe_active", 32'(miso_oe), 32'd1);
    // Mode pins wander mid-frame; the latched mode must hold.
    cpol = 1'($urandom);
    cpha = 1'($urandom);
    if (pha) clk_wait(half - 3);
    cap = '0;
    for (int j = 0; j < nbits; j++) begin
      w = mw[j / DW];
      xfer_bit(w[DW - 1 - (j % DW)], m);
      cap = {cap[DW-2:0], m};
      if ((j % DW) == DW - 1) check("miso_word", 32'(cap), 32'(exp_miso.pop_front()));
    end
    clk_wait(half);
    cs_n = 1'b1;
    clk_wait(half + 6);
    check("busy_idle", 32'(busy), 32'd0);
    check("miso_oe_idle", 32'(miso_oe), 32'd0);
    check("rx_drained", 32'(exp_rx.size()), 32'd0);
    check("underrun_count", 32'(underrun_cnt - u0), 32'(loads - k));
    check("tx_ready_idle", 32'(tx_ready), 32'd1);
    exp_rx.delete();
    exp_miso.delete();
  endtask

  task automatic set_words(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c);
    mw.delete();
    mw.push_back(a);
    mw.push_back(b);
    mw.push_back(c);
  endtask

  task automatic set_tx(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c);
    tw.delete();
    tw.push_back(a);
    tw.push_back(b);
    tw.push_back(c);
  endtask

  initial begin
    logic m;
    logic [DW-1:0] w;
    int   nw;
    int   nbits;
    int   k;
    logic pol;
    logic pha;

    clk_wait(4);
    check_reset_outputs("reset");
    sync_rst = 1'b0;
    clk_wait(6);

    // Mode 0, 0xA5 in, 0x3C out.
    half = 4;
    set_words(8'hA5, 8'h00, 8'h00);
    set_tx(8'h3C, 8'h00, 8'h00);
    do_frame(1'b0, 1'b0, DW, 1);

    // All four modes.
    for (int md = 0; md < 4; md++) begin
      set_words(8'h5A, 8'h00, 8'h00);
      set_tx(8'hC3, 8'h00, 8'h00);
      do_frame(1'(md >> 1), 1'(md), DW, 1);
    end

    // Back-to-back words under one selection.
    set_words(8'h01, 8'h02, 8'h03);
    set_tx(8'h11, 8'h22, 8'h33);
    do_frame(1'b0, 1'b0, 3 * DW, 3);
    do_frame(1'b1, 1'b1, 3 * DW, 3);

    // Underrun: nothing offered before the frame.
    set_words(8'h69, 8'h00, 8'h00);
    do_frame(1'b0, 1'b1, DW, 0);

    // Abort after 5 bits, then a clean frame.
    set_words(8'hF0, 8'h00, 8'h00);
    do_frame(1'b0, 1'b0, 5, 0);
    set_words(8'h7E, 8'h00, 8'h00);
    set_tx(8'h81, 8'h00, 8'h00);
    do_frame(1'b0, 1'b0, DW, 1);

    // Reset mid-frame; the still-selected frame must not be re-entered.
    w = 8'h96;
    cur_cpol = 1'b0;
    cur_cpha = 1'b0;
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    clk_wait(6);
    cs_n = 1'b0;
    clk_wait(3);
    for (int j = 0; j < 3; j++) xfer_bit(w[DW-1-j], m);
    sync_rst = 1'b1;
    clk_wait(1);
    check_reset_outputs("midreset");
    sync_rst = 1'b0;
    for (int j = 3; j < DW; j++) xfer_bit(w[DW-1-j], m);
    check("no_rearm_busy", 32'(busy), 32'd0);
    check("no_rearm_oe", 32'(miso_oe), 32'd0);
    clk_wait(half);
    cs_n = 1'b1;
    clk_wait(10);
    set_words(8'hC7, 8'h00, 8'h00);
    set_tx(8'h5E, 8'h00, 8'h00);
    do_frame(1'b1, 1'b0, DW, 1);

    // Randomized frames, including occasional aborts.
    for (int f = 0; f < 20; f++) begin
      pol  = 1'($urandom);
      pha  = 1'($urandom);
      half = int'($urandom_range(4, 6));
      set_words(DW'($urandom), DW'($urandom), DW'($urandom));
      set_tx(DW'($urandom), DW'($urandom), DW'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        nbits = int'($urandom_range(1, DW - 1));
        k     = int'($urandom_range(0, 1));
      end else begin
        nw    = int'($urandom_range(1, 3));
        nbits = nw * DW;
        k     = int'($urandom_range(0, nw));
      end
      do_frame(pol, pha, nbits, k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
